// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared types and constants for the Game of Life field storage
package gol_pkg;

    localparam int NEIGHBOURS_CNT = 8;

    // Bit positions of each neighbour in the packed neighbour vector
    localparam int NBR_NW = 0;
    localparam int NBR_N  = 1;
    localparam int NBR_NE = 2;
    localparam int NBR_W  = 3;
    localparam int NBR_E  = 4;
    localparam int NBR_SW = 5;
    localparam int NBR_S  = 6;
    localparam int NBR_SE = 7;

    typedef logic [3:0] nbr_cnt_t;

    typedef enum logic {
        FS_IDLE,
        FS_CLEAR
    } field_fsm_t;

    function automatic nbr_cnt_t nbr_popcount(input logic [NEIGHBOURS_CNT-1:0] v);
        nbr_cnt_t c;
        c = '0;
        for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
            c = c + nbr_cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gol_nbr_addr.sv
// rtl/gol_nbr_addr.sv - neighbour coordinate generator with dead-border or torus edges
module gol_nbr_addr
    import gol_pkg::*;
#(
    parameter int FIELD_W   = 64,
    parameter int FIELD_H   = 48,
    parameter int WRAP_MODE = 0,
    localparam int XW = $clog2(FIELD_W),
    localparam int YW = $clog2(FIELD_H)
) (
    input  logic [XW-1:0]                     x,
    input  logic [YW-1:0]                     y,
    output logic [NEIGHBOURS_CNT-1:0][XW-1:0] nbr_x,
    output logic [NEIGHBOURS_CNT-1:0][YW-1:0] nbr_y,
    output logic [NEIGHBOURS_CNT-1:0]         nbr_valid
);

    logic [XW-1:0] xm, xp;
    logic [YW-1:0] ym, yp;
    logic          xm_ok, xp_ok, x_ok;
    logic          ym_ok, yp_ok, y_ok;

    always_comb begin
        x_ok = 32'(x) < FIELD_W;
        y_ok = 32'(y) < FIELD_H;

        // Edge coordinates either wrap to the opposite side or are marked invalid
        if (x == '0) begin
            xm    = XW'(FIELD_W - 1);
            xm_ok = (WRAP_MODE != 0);
        end else begin
            xm    = x - 1'b1;
            xm_ok = 32'(xm) < FIELD_W;
        end
        if (32'(x) == FIELD_W - 1) begin
            xp    = '0;
            xp_ok = (WRAP_MODE != 0);
        end else begin
            xp    = XW'(32'(x) + 1);
            xp_ok = (32'(x) + 1) < FIELD_W;
        end

        if (y == '0) begin
            ym    = YW'(FIELD_H - 1);
            ym_ok = (WRAP_MODE != 0);
        end else begin
            ym    = y - 1'b1;
            ym_ok = 32'(ym) < FIELD_H;
        end
        if (32'(y) == FIELD_H - 1) begin
            yp    = '0;
            yp_ok = (WRAP_MODE != 0);
        end else begin
            yp    = YW'(32'(y) + 1);
            yp_ok = (32'(y) + 1) < FIELD_H;
        end

        nbr_x[NBR_NW] = xm; nbr_y[NBR_NW] = ym; nbr_valid[NBR_NW] = xm_ok & ym_ok;
        nbr_x[NBR_N]  = x;  nbr_y[NBR_N]  = ym; nbr_valid[NBR_N]  = x_ok  & ym_ok;
        nbr_x[NBR_NE] = xp; nbr_y[NBR_NE] = ym; nbr_valid[NBR_NE] = xp_ok & ym_ok;
        nbr_x[NBR_W]  = xm; nbr_y[NBR_W]  = y;  nbr_valid[NBR_W]  = xm_ok & y_ok;
        nbr_x[NBR_E]  = xp; nbr_y[NBR_E]  = y;  nbr_valid[NBR_E]  = xp_ok & y_ok;
        nbr_x[NBR_SW] = xm; nbr_y[NBR_SW] = yp; nbr_valid[NBR_SW] = xm_ok & yp_ok;
        nbr_x[NBR_S]  = x;  nbr_y[NBR_S]  = yp; nbr_valid[NBR_S]  = x_ok  & yp_ok;
        nbr_x[NBR_SE] = xp; nbr_y[NBR_SE] = yp; nbr_valid[NBR_SE] = xp_ok & yp_ok;
    end

endmodule

// File: rtl/field_ram_dbuf.sv
// rtl/field_ram_dbuf.sv - double-buffered Game of Life field with swap and row-clear sequencer
module field_ram_dbuf
    import gol_pkg::*;
#(
    parameter int FIELD_W   = 64,
    parameter int FIELD_H   = 48,
    parameter int WRAP_MODE = 0,
    localparam int X_ADR_SIZE = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [X_ADR_SIZE-1:0]     i_cell_x_adr_prw1,
    input  logic [Y_ADR_SIZE-1:0]     i_cell_y_adr_prw1,
    input  logic                      i_w_en_p1,
    input  logic                      i_new_cell_state_p1,
    output logic                      o_cell_state_pr1,
    output logic [NEIGHBOURS_CNT-1:0] o_nbrs_pr1,
    output logic [3:0]                o_nbr_cnt_pr1,
    input  logic [X_ADR_SIZE-1:0]     i_cell_x_adr_pr2,
    input  logic [Y_ADR_SIZE-1:0]     i_cell_y_adr_pr2,
    input  logic                      i_w_en_p2,
    input  logic                      i_new_cell_state_p2,
    output logic                      o_cell_state_pr2,
    input  logic                      i_swap,
    input  logic                      i_clear,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_gen_parity
);

    logic [1:0][FIELD_H-1:0][FIELD_W-1:0] mem;
    logic [FIELD_H-1:0][FIELD_W-1:0]      cur;
    logic                                 sel;
    logic                                 nsel;
    field_fsm_t                           state;
    logic [Y_ADR_SIZE-1:0]                row_cnt;
    logic                                 busy_q;
    logic                                 done_q;

    logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] nbr_x;
    logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] nbr_y;
    logic [NEIGHBOURS_CNT-1:0]                 nbr_valid;
    logic [NEIGHBOURS_CNT-1:0]                 nbrs;

    logic p1_in, p2_in;

    function automatic logic in_field(input logic [X_ADR_SIZE-1:0] x,
                                      input logic [Y_ADR_SIZE-1:0] y);
        return (32'(x) < FIELD_W) && (32'(y) < FIELD_H);
    endfunction

    assign nsel  = ~sel;
    assign cur   = mem[sel];
    assign p1_in = in_field(i_cell_x_adr_prw1, i_cell_y_adr_prw1);
    assign p2_in = in_field(i_cell_x_adr_pr2, i_cell_y_adr_pr2);

    gol_nbr_addr #(
        .FIELD_W   (FIELD_W),
        .FIELD_H   (FIELD_H),
        .WRAP_MODE (WRAP_MODE)
    ) u_nbr_addr (
        .x         (i_cell_x_adr_prw1),
        .y         (i_cell_y_adr_prw1),
        .nbr_x     (nbr_x),
        .nbr_y     (nbr_y),
        .nbr_valid (nbr_valid)
    );

    always_comb begin
        nbrs = '0;
        for (int k = 0; k < NEIGHBOURS_CNT; k++) begin
            if (nbr_valid[k]) begin
                nbrs[k] = cur[nbr_y[k]][nbr_x[k]];
            end
        end
    end

    assign o_cell_state_pr1 = p1_in ? cur[i_cell_y_adr_prw1][i_cell_x_adr_prw1] : 1'b0;
    assign o_cell_state_pr2 = p2_in ? cur[i_cell_y_adr_pr2][i_cell_x_adr_pr2] : 1'b0;
    assign o_nbrs_pr1       = nbrs;
    assign o_nbr_cnt_pr1    = nbr_popcount(nbrs);
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_gen_parity     = sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem     <= '0;
            sel     <= 1'b0;
            state   <= FS_IDLE;
            row_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                FS_IDLE: begin
                    // Writes use the pre-swap bank selection, so a swap in the same cycle is safe
                    if (i_w_en_p1 && p1_in) begin
                        mem[nsel][i_cell_y_adr_prw1][i_cell_x_adr_prw1] <= i_new_cell_state_p1;
                    end
                    if (i_w_en_p2 && p2_in) begin
                        mem[sel][i_cell_y_adr_pr2][i_cell_x_adr_pr2] <= i_new_cell_state_p2;
                    end
                    if (i_clear) begin
                        state   <= FS_CLEAR;
                        busy_q  <= 1'b1;
                        row_cnt <= '0;
                    end else if (i_swap) begin
                        sel <= nsel;
                    end
                end
                FS_CLEAR: begin
                    mem[0][row_cnt] <= '0;
                    mem[1][row_cnt] <= '0;
                    // Registered done is raised one row early so it coincides with the last row
                    done_q <= (row_cnt == Y_ADR_SIZE'(FIELD_H - 2));
                    if (row_cnt == Y_ADR_SIZE'(FIELD_H - 1)) begin
                        state   <= FS_IDLE;
                        busy_q  <= 1'b0;
                        row_cnt <= '0;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_field_ram_dbuf.sv
// tb/tb_field_ram_dbuf.sv - self-checking bench for field_ram_dbuf (dead-border and torus instances)
module tb_field_ram_dbuf;

    localparam int W  = 64;
    localparam int H  = 48;
    localparam int XW = 6;
    localparam int YW = 6;

    localparam int K_R   = 0;
    localparam int K_W2  = 1;
    localparam int K_W1  = 2;
    localparam int K_SW  = 3;
    localparam int K_SWW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [XW-1:0] x1, x2;
    logic [YW-1:0] y1, y2;
    logic          w1, d1, w2, d2, swap, clr;

    logic       c1_0, c2_0, busy_0, done_0, par_0;
    logic [7:0] nb_0;
    logic [3:0] cnt_0;
    logic       c1_1, c2_1, busy_1, done_1, par_1;
    logic [7:0] nb_1;
    logic [3:0] cnt_1;

    always #5 clk = ~clk;

    field_ram_dbuf #(.FIELD_W(W), .FIELD_H(H), .WRAP_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_cell_x_adr_prw1(x1), .i_cell_y_adr_prw1(y1),
        .i_w_en_p1(w1), .i_new_cell_state_p1(d1),
        .o_cell_state_pr1(c1_0), .o_nbrs_pr1(nb_0), .o_nbr_cnt_pr1(cnt_0),
        .i_cell_x_adr_pr2(x2), .i_cell_y_adr_pr2(y2),
        .i_w_en_p2(w2), .i_new_cell_state_p2(d2),
        .o_cell_state_pr2(c2_0),
        .i_swap(swap), .i_clear(clr),
        .o_busy(busy_0), .o_done(done_0), .o_gen_parity(par_0)
    );

    field_ram_dbuf #(.FIELD_W(W), .FIELD_H(H), .WRAP_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_cell_x_adr_prw1(x1), .i_cell_y_adr_prw1(y1),
        .i_w_en_p1(w1), .i_new_cell_state_p1(d1),
        .o_cell_state_pr1(c1_1), .o_nbrs_pr1(nb_1), .o_nbr_cnt_pr1(cnt_1),
        .i_cell_x_adr_pr2(x2), .i_cell_y_adr_pr2(y2),
        .i_w_en_p2(w2), .i_new_cell_state_p2(d2),
        .o_cell_state_pr2(c2_1),
        .i_swap(swap), .i_clear(clr),
        .o_busy(busy_1), .o_done(done_1), .o_gen_parity(par_1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference field: two banks plus which one is current
    bit mb[2][H][W];
    int msel;

    typedef struct {
        int         kind;
        int         x;
        int         y;
        bit         d;
        bit         e_cell;
        int         e_cnt0;
        int         e_cnt1;
        logic [7:0] e_nb0;
        logic [7:0] e_nb1;
        bit         e_par;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(int kind, int x, int y, bit d, bit e_cell, int e_cnt0,
                                 int e_cnt1, logic [7:0] e_nb0, logic [7:0] e_nb1, bit e_par);
        vec_t v;
        v.kind = kind; v.x = x; v.y = y; v.d = d; v.e_cell = e_cell;
        v.e_cnt0 = e_cnt0; v.e_cnt1 = e_cnt1; v.e_nb0 = e_nb0; v.e_nb1 = e_nb1; v.e_par = e_par;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_nbrs(int x, int y, int wrap);
        logic [7:0] r;
        int k, nx, ny;
        r = '0;
        k = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0)) begin
                    nx = x + dx;
                    ny = y + dy;
                    if (wrap != 0) begin
                        nx = (nx + W) % W;
                        ny = (ny + H) % H;
                    end
                    if (nx >= 0 && nx < W && ny >= 0 && ny < H) r[k] = mb[msel][ny][nx];
                    k++;
                end
            end
        end
        return r;
    endfunction

    task automatic model_zero();
        for (int b = 0; b < 2; b++)
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++)
                    mb[b][yy][xx] = 1'b0;
    endtask

    task automatic idle_inputs();
        w1 = 0; d1 = 0; w2 = 0; d2 = 0; swap = 0; clr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_write(input bit a_w1, input int a_x1, input int a_y1, input bit a_d1,
                               input bit a_w2, input int a_x2, input int a_y2, input bit a_d2,
                               input bit a_sw);
        w1 = a_w1; x1 = XW'(a_x1); y1 = YW'(a_y1); d1 = a_d1;
        w2 = a_w2; x2 = XW'(a_x2); y2 = YW'(a_y2); d2 = a_d2;
        swap = a_sw;
        cyc();
        if (a_w1 && a_x1 < W && a_y1 < H) mb[1 - msel][a_y1][a_x1] = a_d1;
        if (a_w2 && a_x2 < W && a_y2 < H) mb[msel][a_y2][a_x2] = a_d2;
        if (a_sw) msel = 1 - msel;
        idle_inputs();
    endtask

    task automatic sweep_zero(input string name);
        int nz;
        nz = 0;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                x1 = XW'(xx); y1 = YW'(yy); x2 = XW'(xx); y2 = YW'(yy);
                #1;
                if (c1_0 !== 1'b0 || c2_0 !== 1'b0 || c1_1 !== 1'b0) nz++;
            end
        end
        chk(name, nz, 0);
    endtask

    task automatic wait_clear(output int n, output int dn_cnt, output int dn_at, input bit junk);
        n = 0; dn_cnt = 0; dn_at = 0;
        while (busy_0 === 1'b1 && n < 200) begin
            n++;
            if (done_0 === 1'b1) begin
                dn_cnt++;
                dn_at = n;
            end
            if (junk) begin
                w1 = 1; d1 = 1; w2 = 1; d2 = 1; swap = 1; clr = 1;
                x1 = XW'(n % W); y1 = YW'(n % H); x2 = XW'((n * 3) % W); y2 = YW'(n % H);
            end
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dn_cnt, dn_at, p_before, rx, ry, rx2, ry2, ax, ay, bx, by;

        rst = 1;
        idle_inputs();
        x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        msel = 0;
        model_zero();
        repeat (2) cyc();
        rst = 0;
        #1;
        chk("rst_cell1", c1_0, 0);
        chk("rst_cell2", c2_0, 0);
        chk("rst_cnt", cnt_0, 0);
        chk("rst_nbrs_wrap", nb_1, 0);
        chk("rst_busy", busy_0, 0);
        chk("rst_done", done_0, 0);
        chk("rst_parity", par_0, 0);

        tbl.push_back(mkv(K_W2, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_W2, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_W2, 1, 2, 1, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_R,  0, 1, 0, 0, 3, 3, 8'h94, 8'h94, 0));
        tbl.push_back(mkv(K_R,  1, 1, 0, 1, 2, 2, 8'h42, 8'h42, 0));
        tbl.push_back(mkv(K_R,  1, 47, 0, 0, 0, 1, 8'h00, 8'h40, 0));
        tbl.push_back(mkv(K_W1, 5, 5, 1, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_R,  5, 5, 0, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_SW, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_R,  5, 5, 0, 1, 0, 0, 8'h00, 8'h00, 1));
        tbl.push_back(mkv(K_R,  1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 1));
        tbl.push_back(mkv(K_W2, 63, 47, 1, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_R,  0, 0, 0, 0, 0, 1, 8'h00, 8'h01, 1));
        tbl.push_back(mkv(K_R,  62, 46, 0, 0, 1, 1, 8'h80, 8'h80, 1));
        tbl.push_back(mkv(K_R,  63, 47, 0, 1, 0, 0, 8'h00, 8'h00, 1));
        tbl.push_back(mkv(K_W2, 3, 50, 1, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_R,  3, 50, 0, 0, 0, 0, 8'h00, 8'h00, 1));
        tbl.push_back(mkv(K_R,  3, 2, 0, 0, 0, 0, 8'h00, 8'h00, 1));
        tbl.push_back(mkv(K_SWW, 10, 10, 1, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_R,  10, 10, 0, 0, 1, 1, 8'h10, 8'h10, 0));
        tbl.push_back(mkv(K_R,  11, 10, 0, 1, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mkv(K_R,  1, 1, 0, 1, 2, 2, 8'h42, 8'h42, 0));
        tbl.push_back(mkv(K_R,  0, 1, 0, 0, 3, 3, 8'h94, 8'h94, 0));

        foreach (tbl[i]) begin
            case (tbl[i].kind)
                K_W2:  apply_write(0, 0, 0, 0, 1, tbl[i].x, tbl[i].y, tbl[i].d, 0);
                K_W1:  apply_write(1, tbl[i].x, tbl[i].y, tbl[i].d, 0, 0, 0, 0, 0);
                K_SW:  apply_write(0, 0, 0, 0, 0, 0, 0, 0, 1);
                K_SWW: apply_write(1, tbl[i].x + 1, tbl[i].y, tbl[i].d,
                                   1, tbl[i].x, tbl[i].y, tbl[i].d, 1);
                default: begin
                    x1 = XW'(tbl[i].x); y1 = YW'(tbl[i].y);
                    x2 = XW'(tbl[i].x); y2 = YW'(tbl[i].y);
                    #1;
                    chk($sformatf("vec%0d_cell1", i), c1_0, tbl[i].e_cell);
                    chk($sformatf("vec%0d_cell2", i), c2_0, tbl[i].e_cell);
                    chk($sformatf("vec%0d_cell1_wrap", i), c1_1, tbl[i].e_cell);
                    chk($sformatf("vec%0d_cnt", i), cnt_0, tbl[i].e_cnt0);
                    chk($sformatf("vec%0d_cnt_wrap", i), cnt_1, tbl[i].e_cnt1);
                    chk($sformatf("vec%0d_nbrs", i), nb_0, tbl[i].e_nb0);
                    chk($sformatf("vec%0d_nbrs_wrap", i), nb_1, tbl[i].e_nb1);
                    chk($sformatf("vec%0d_parity", i), par_0, tbl[i].e_par);
                end
            endcase
        end

        // Random writes/swaps concentrated near the corners to exercise edge handling
        for (int it = 0; it < 400; it++) begin
            ax = $urandom % 12; if (ax >= 6) ax += 52;
            ay = $urandom % 14; if (ay >= 6) ay += 36;
            bx = $urandom % 12; if (bx >= 6) bx += 52;
            by = $urandom % 12; if (by >= 6) by += 36;
            apply_write(1'($urandom % 2), ax, ay, 1'($urandom % 2),
                        1'($urandom % 2), bx, by, 1'($urandom % 2),
                        ($urandom % 8) == 0);
            rx = $urandom % 12; if (rx >= 6) rx += 52;
            ry = $urandom % 12; if (ry >= 6) ry += 36;
            rx2 = $urandom % 12; if (rx2 >= 6) rx2 += 52;
            ry2 = $urandom % 12; if (ry2 >= 6) ry2 += 36;
            x1 = XW'(rx); y1 = YW'(ry); x2 = XW'(rx2); y2 = YW'(ry2);
            #1;
            chk("rnd_cell1", c1_0, mb[msel][ry][rx]);
            chk("rnd_cell2", c2_1, mb[msel][ry2][rx2]);
            chk("rnd_nbrs", nb_0, m_nbrs(rx, ry, 0));
            chk("rnd_nbrs_wrap", nb_1, m_nbrs(rx, ry, 1));
            chk("rnd_cnt", cnt_0, $countones(m_nbrs(rx, ry, 0)));
            chk("rnd_cnt_wrap", cnt_1, $countones(m_nbrs(rx, ry, 1)));
            chk("rnd_parity", par_0, msel);
        end

        // Clear with junk writes/swaps/clears held during busy
        p_before = msel;
        clr = 1;
        cyc();
        clr = 0;
        chk("clr_busy_start", busy_0, 1);
        wait_clear(n, dn_cnt, dn_at, 1);
        chk("clr_busy_cycles", n, H);
        chk("clr_done_cycle", dn_at, H);
        chk("clr_done_count", dn_cnt, 1);
        chk("clr_busy_end", busy_0, 0);
        chk("clr_parity", par_0, p_before);
        model_zero();
        sweep_zero("clr_cur_zero");
        apply_write(0, 0, 0, 0, 0, 0, 0, 0, 1);
        sweep_zero("clr_nxt_zero");

        // Clear and swap in the same cycle: clear wins
        apply_write(0, 0, 0, 0, 1, 2, 2, 1, 0);
        p_before = msel;
        clr = 1; swap = 1;
        cyc();
        idle_inputs();
        chk("clrswap_parity", par_0, p_before);
        chk("clrswap_busy", busy_0, 1);
        wait_clear(n, dn_cnt, dn_at, 0);
        chk("clrswap_done_count", dn_cnt, 1);
        chk("clrswap_parity_end", par_0, p_before);
        model_zero();
        x2 = XW'(2); y2 = YW'(2);
        #1;
        chk("clrswap_cell", c2_0, 0);

        // Reset during the tenth clear cycle
        apply_write(1, 4, 4, 1, 1, 4, 4, 1, 1);
        chk("rstclr_parity_pre", par_0, msel);
        clr = 1;
        cyc();
        clr = 0;
        dn_cnt = 0;
        for (int c = 1; c < 10; c++) begin
            if (done_0 === 1'b1) dn_cnt++;
            cyc();
        end
        rst = 1;
        cyc();
        rst = 0;
        chk("rstclr_busy", busy_0, 0);
        chk("rstclr_done", done_0, 0);
        chk("rstclr_parity", par_0, 0);
        for (int c = 0; c < 60; c++) begin
            if (done_0 === 1'b1 || busy_0 === 1'b1) dn_cnt++;
            cyc();
        end
        chk("rstclr_no_done", dn_cnt, 0);
        msel = 0;
        model_zero();
        sweep_zero("rstclr_cur_zero");
        apply_write(0, 0, 0, 0, 0, 0, 0, 0, 1);
        sweep_zero("rstclr_nxt_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
